// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply (radix-2 shift-add) and restoring divide for the EX stage.
// Optional macro MDU_ZERO_SKIP_EN: zero-operand operations finish the cycle after start.
module mul_div_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 res_sign_q, res_sign_d;
    logic                 rem_sign_q, rem_sign_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         opnd_q, opnd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [W-1:0]         lo_q, lo_d;
    logic [W-1:0]         hi_q, hi_d;

    logic                 a_neg_s, b_neg_s;
    logic [W-1:0]         a_mag_s, b_mag_s;
    logic                 zero_skip_s;
    logic [W:0]           add_s;
    logic [W:0]           rem_sh_s;
    logic [W-1:0]         diff_s;
    logic [2*W-1:0]       prod_s;
    logic [W-1:0]         quo_s, rem_s;

    // Operand magnitudes/signs at issue and the per-iteration datapath
    always_comb begin
        a_neg_s = ~op[0] & operand_a[W-1];
        b_neg_s = ~op[0] & operand_b[W-1];
        a_mag_s = a_neg_s ? (-operand_a) : operand_a;
        b_mag_s = b_neg_s ? (-operand_b) : operand_b;
`ifdef MDU_ZERO_SKIP_EN
        zero_skip_s = op[1] ? ((operand_a == {W{1'b0}}) && (operand_b != {W{1'b0}}))
                            : ((operand_a == {W{1'b0}}) || (operand_b == {W{1'b0}}));
`else
        zero_skip_s = 1'b0;
`endif
        // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
        add_s    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        rem_sh_s = {acc_q[2*W-1:W], acc_q[W-1]};
        diff_s   = rem_sh_s[W-1:0] - opnd_q;
        prod_s   = res_sign_q ? (-acc_q) : acc_q;
        quo_s    = res_sign_q ? (-acc_q[W-1:0]) : acc_q[W-1:0];
        rem_s    = rem_sign_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        res_sign_d = res_sign_q;
        rem_sign_d = rem_sign_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    if (op[1] && (operand_b == {W{1'b0}})) begin
                        done_d = 1'b1;
                        busy_d = 1'b1;
                        dbz_d  = 1'b1;
                        lo_d   = {W{1'b1}};
                        hi_d   = operand_a;
                    end else if (zero_skip_s) begin
                        done_d = 1'b1;
                        busy_d = 1'b1;
                        dbz_d  = 1'b0;
                        lo_d   = {W{1'b0}};
                        hi_d   = {W{1'b0}};
                    end else begin
                        state_d    = CALC;
                        busy_d     = 1'b1;
                        cnt_d      = CNT_WIDTH'(DATA_WIDTH);
                        is_div_d   = op[1];
                        res_sign_d = a_neg_s ^ b_neg_s;
                        rem_sign_d = a_neg_s;
                        acc_d      = {{W{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
                        opnd_d     = op[1] ? b_mag_s : a_mag_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (rem_sh_s >= {1'b0, opnd_q}) begin
                        acc_d = {diff_s, acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh_s[W-1:0], acc_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {add_s, acc_q[W-1:1]};
                end
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = SIGN;
                end else begin
                    state_d = CALC;
                end
            end
            SIGN: begin
                if (is_div_q) begin
                    lo_d = quo_s;
                    hi_d = rem_s;
                end else begin
                    lo_d = prod_s[W-1:0];
                    hi_d = prod_s[2*W-1:W];
                end
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            res_sign_q <= 1'b0;
            rem_sign_q <= 1'b0;
            acc_q      <= {(2*W){1'b0}};
            opnd_q     <= {W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            lo_q       <= {W{1'b0}};
            hi_q       <= {W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            res_sign_q <= res_sign_d;
            rem_sign_q <= rem_sign_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results come from native SV arithmetic.
`timescale 1ns/1ps
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // lat = clock edges after the start-sampling edge until done is visible
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          sa, sb, q, r;
        logic [31:0] p;
        bit          zero;
        sa = $signed(a);
        sb = $signed(b);
        e.dbz = 1'b0;
        e.lat = 17;
        case (o)
            2'd0: begin p = sa * sb; e.lo = p[15:0]; e.hi = p[31:16]; end
            2'd1: begin p = {16'h0000, a} * {16'h0000, b}; e.lo = p[15:0]; e.hi = p[31:16]; end
            default: begin
                if (b == 16'h0000) begin
                    e.lo = 16'hFFFF; e.hi = a; e.dbz = 1'b1; e.lat = 0;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[15:0]; e.hi = r[15:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        zero = o[1] ? (a == 16'h0000 && b != 16'h0000) : (a == 16'h0000 || b == 16'h0000);
`ifdef MDU_ZERO_SKIP_EN
        if (zero) e.lat = 0;
`else
        if (zero) e.lat = 17;
`endif
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at #1 in the cycle after done
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input bit poke_busy, input bit poke_done);
        exp_t e;
        int   k;
        bit   busy_ok;
        sb_q.push_back(model(o, a, b));
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = 16'($urandom); operand_b = 16'($urandom); op = 2'($urandom_range(0, 3));
        k = 0;
        busy_ok = 1'b1;
        while (!done && k < 40) begin
            if (!busy) busy_ok = 1'b0;
            start = poke_busy && (k == 3);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(k), 32'(e.lat));
        check("busy_during", 32'(busy_ok && busy), 32'd1);
        check("result_lo", 32'(result_lo), 32'(e.lo));
        check("result_hi", 32'(result_hi), 32'(e.hi));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        if (poke_done) begin
            start = 1'b1; op = 2'b11; operand_b = 16'h0000;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = 16'h0000; operand_b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo", 32'(result_lo), 32'd0);
        check("rst_hi", 32'(result_hi), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 16'hFFFD, 16'h0007, 1'b0, 1'b0);
        run_op(2'd1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_op(2'd2, 16'hFFF9, 16'h0002, 1'b0, 1'b1);
        run_op(2'd2, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
        run_op(2'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(2'd2, 16'h1234, 16'h0000, 1'b0, 1'b0);
        run_op(2'd3, 16'd10, 16'd3, 1'b0, 1'b0);
        run_op(2'd3, 16'hABCD, 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of 7*9 must abort it without a done pulse
        op = 2'd0; operand_a = 16'd7; operand_b = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_lo", 32'(result_lo), 32'd0);
        check("midrst_hi", 32'(result_hi), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        n = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("midrst_no_done", 32'(n), 32'd0);

        run_op(2'd0, 16'h0000, 16'h0005, 1'b0, 1'b0);
        run_op(2'd1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        run_op(2'd2, 16'h0000, 16'h0007, 1'b0, 1'b0);
        run_op(2'd3, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(2'd2, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op(2'(i % 4), 16'($urandom), 16'($urandom_range(1, 65535)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
